// File: rtl/disp_scan.sv
// disp_scan: 4-digit multiplexed 7-segment scan driver with tear-free
// frame-synchronous loading of new display data.
// Optional build macro: DISP_SCAN_LZB_EN enables leading-zero blanking.
module disp_scan #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        load,
    output logic        load_ack,
    output logic [3:0]  bcd,
    output logic [3:0]  an,
    output logic        dp,
    output logic        frame_tick
);

    localparam int unsigned CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] TC_VAL = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt;
    logic [1:0]    sel;
    logic [15:0]   act_val;
    logic [3:0]    act_dp;
    logic [15:0]   pend_val;
    logic [3:0]    pend_dp;
    logic          pend_flag;

    logic [CW-1:0] cnt_nxt;
    logic [1:0]    sel_nxt;
    logic [15:0]   act_val_nxt;
    logic [3:0]    act_dp_nxt;
    logic [15:0]   pend_val_nxt;
    logic [3:0]    pend_dp_nxt;
    logic          pend_flag_nxt;
    logic          tc_c;
    logic          boundary_c;
    logic          ack_nxt;
    logic [3:0]    nib_c;
    logic          blank_c;
    logic [3:0]    an_nxt;
    logic [3:0]    bcd_nxt;
    logic          dp_nxt;

    // Prescaler, digit select and frame boundary detection
    always_comb begin
        tc_c       = (cnt == TC_VAL);
        boundary_c = tc_c && (sel == 2'd3);
        cnt_nxt    = tc_c ? '0 : cnt + CW'(1);
        sel_nxt    = tc_c ? sel + 2'd1 : sel;
    end

    // Pending/active data path: a load on the boundary cycle bypasses pending
    always_comb begin
        act_val_nxt   = act_val;
        act_dp_nxt    = act_dp;
        pend_val_nxt  = pend_val;
        pend_dp_nxt   = pend_dp;
        pend_flag_nxt = pend_flag;
        ack_nxt       = 1'b0;
        if (boundary_c) begin
            pend_flag_nxt = 1'b0;
            ack_nxt       = load || pend_flag;
            if (load) begin
                act_val_nxt = value;
                act_dp_nxt  = dp_in;
            end else if (pend_flag) begin
                act_val_nxt = pend_val;
                act_dp_nxt  = pend_dp;
            end
        end else if (load) begin
            pend_val_nxt  = value;
            pend_dp_nxt   = dp_in;
            pend_flag_nxt = 1'b1;
        end
    end

    // Digit output for the slot that starts at the next TC edge
    always_comb begin
        nib_c   = 4'h0;
        blank_c = 1'b0;
        case (sel_nxt)
            2'd0: nib_c = act_val_nxt[3:0];
            2'd1: nib_c = act_val_nxt[7:4];
            2'd2: nib_c = act_val_nxt[11:8];
            default: nib_c = act_val_nxt[15:12];
        endcase
`ifdef DISP_SCAN_LZB_EN
        case (sel_nxt)
            2'd1: blank_c = (act_val_nxt[15:4] == 12'h000);
            2'd2: blank_c = (act_val_nxt[15:8] == 8'h00);
            2'd3: blank_c = (act_val_nxt[15:12] == 4'h0);
            default: blank_c = 1'b0;
        endcase
`else
        blank_c = 1'b0;
`endif
        if (blank_c) begin
            an_nxt  = 4'b1111;
            bcd_nxt = 4'h0;
            dp_nxt  = 1'b1;
        end else begin
            an_nxt  = ~(4'b0001 << sel_nxt);
            bcd_nxt = nib_c;
            dp_nxt  = ~act_dp_nxt[sel_nxt];
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            sel        <= 2'd0;
            act_val    <= 16'h0000;
            act_dp     <= 4'h0;
            pend_val   <= 16'h0000;
            pend_dp    <= 4'h0;
            pend_flag  <= 1'b0;
            an         <= 4'b1110;
            bcd        <= 4'h0;
            dp         <= 1'b1;
            load_ack   <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            sel        <= sel_nxt;
            act_val    <= act_val_nxt;
            act_dp     <= act_dp_nxt;
            pend_val   <= pend_val_nxt;
            pend_dp    <= pend_dp_nxt;
            pend_flag  <= pend_flag_nxt;
            load_ack   <= ack_nxt;
            frame_tick <= boundary_c;
            if (tc_c) begin
                an  <= an_nxt;
                bcd <= bcd_nxt;
                dp  <= dp_nxt;
            end
        end
    end

endmodule

// File: tb/tb_disp_scan.sv
// Bench for disp_scan with REFRESH_DIV=4 (16-cycle frames).
// Honors DISP_SCAN_LZB_EN for expected blanking.
module tb_disp_scan;

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dpi;
        logic [3:0]  blank;   // slots blanked when leading-zero blanking is on
    } vec_t;

`ifdef DISP_SCAN_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        load;
    logic        load_ack;
    logic [3:0]  bcd;
    logic [3:0]  an;
    logic        dp;
    logic        frame_tick;

    int total = 0;
    int bad   = 0;

    disp_scan #(.REFRESH_DIV(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .dp_in      (dp_in),
        .load       (load),
        .load_ack   (load_ack),
        .bcd        (bcd),
        .an         (an),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_an", 16'(an), 16'h000e);
        chk("rst_bcd", 16'(bcd), 16'h0000);
        chk("rst_dp", 16'(dp), 16'h0001);
        chk("rst_ack", 16'(load_ack), 16'h0000);
        chk("rst_tick", 16'(frame_tick), 16'h0000);
    endtask

    // Wait (bounded) for frame_tick; returns cycles waited
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!frame_tick && n < 64);
    endtask

    // Check one full frame starting at its first cycle, optionally loading twice
    task automatic check_frame(input vec_t cur, input logic ack_exp,
                               input vec_t l1, input int c1,
                               input vec_t l2, input int c2);
        logic [3:0] e_an;
        logic [3:0] e_bcd;
        logic       e_dp;
        logic [3:0] one;
        for (int c = 0; c < 16; c++) begin
            int k;
            k = c / 4;
            one = 4'b0001;
            if (LZB && cur.blank[k]) begin
                e_an  = 4'b1111;
                e_bcd = 4'h0;
                e_dp  = 1'b1;
            end else begin
                e_an  = ~(one << k);
                e_bcd = cur.value[4*k +: 4];
                e_dp  = ~cur.dpi[k];
            end
            chk($sformatf("an v=%h c%0d", cur.value, c), 16'(an), 16'(e_an));
            chk($sformatf("bcd v=%h c%0d", cur.value, c), 16'(bcd), 16'(e_bcd));
            chk($sformatf("dp v=%h c%0d", cur.value, c), 16'(dp), 16'(e_dp));
            chk($sformatf("tick c%0d", c), 16'(frame_tick), 16'(c == 0));
            chk($sformatf("ack v=%h c%0d", cur.value, c), 16'(load_ack),
                16'((c == 0) ? ack_exp : 1'b0));
            load = 1'b0;
            if (c == c1) begin
                load = 1'b1; value = l1.value; dp_in = l1.dpi;
            end
            if (c == c2) begin
                load = 1'b1; value = l2.value; dp_in = l2.dpi;
            end
            step();
        end
        load = 1'b0;
    endtask

    vec_t tbl[6];
    vec_t zero_v, none_v, prev;
    vec_t v1111, v2222, v3333, v4444, v5555, v9999;
    logic ack;
    int   n;

    initial begin
        tbl[0] = '{16'h1234, 4'b0010, 4'b0000};
        tbl[1] = '{16'h5678, 4'b0000, 4'b0000};
        tbl[2] = '{16'h0070, 4'b0000, 4'b1100};
        tbl[3] = '{16'h0000, 4'b0000, 4'b1110};
        tbl[4] = '{16'hABCD, 4'b1111, 4'b0000};
        tbl[5] = '{16'h0305, 4'b1000, 4'b1000};
        zero_v = '{16'h0000, 4'b0000, 4'b1110};
        none_v = '{16'h0000, 4'b0000, 4'b0000};
        v1111  = '{16'h1111, 4'b0000, 4'b0000};
        v2222  = '{16'h2222, 4'b0100, 4'b0000};
        v3333  = '{16'h3333, 4'b0001, 4'b0000};
        v4444  = '{16'h4444, 4'b0000, 4'b0000};
        v5555  = '{16'h5555, 4'b1000, 4'b0000};
        v9999  = '{16'h9999, 4'b1111, 4'b0000};

        reset = 1'b1; load = 1'b0; value = 16'h0; dp_in = 4'h0;
        step();
        step();
        chk_reset_state();
        reset = 1'b0;

        wait_tick(n);
        chk("first_tick_cycles", 16'(n), 16'd16);

        // Table: each frame checks the current data while loading the next mid-frame
        prev = zero_v;
        ack  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check_frame(prev, ack, tbl[i], 6, none_v, -1);
            prev = tbl[i];
            ack  = 1'b1;
        end
        check_frame(prev, 1'b1, none_v, -1, none_v, -1);

        // Last-wins: two loads in one frame, one ack
        check_frame(prev, 1'b0, v1111, 2, v2222, 9);
        // Boundary-cycle load overrides older pending data
        check_frame(v2222, 1'b1, v4444, 5, v5555, 15);
        check_frame(v5555, 1'b1, none_v, -1, none_v, -1);
        // Boundary-cycle load with nothing pending
        check_frame(v5555, 1'b0, none_v, -1, v3333, 15);
        check_frame(v3333, 1'b1, none_v, -1, none_v, -1);

        // Reset mid-frame with a pending load
        step(); step(); step();
        load = 1'b1; value = v9999.value; dp_in = v9999.dpi;
        step();
        load = 1'b0;
        step();
        reset = 1'b1;
        step();
        chk_reset_state();
        reset = 1'b0;
        wait_tick(n);
        chk("post_reset_tick_cycles", 16'(n), 16'd16);
        check_frame(zero_v, 1'b0, none_v, -1, none_v, -1);
        check_frame(zero_v, 1'b0, none_v, -1, none_v, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/disp_scan.md
DISP_SCAN -- requirements
Module: disp_scan

Interface
REQ-001 SHALL provide parameter REFRESH_DIV, default 100000, clock cycles each digit stays lit (legal range 2..2^20).
REQ-002 SHALL provide port clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port value  input  16  four hex/BCD digits; [3:0] digit0 (rightmost) .. [15:12] digit3.
REQ-005 SHALL provide port dp_in  input  4  decimal-point requests, bit i for digit i, active-high.
REQ-006 SHALL provide port load  input  1  one-cycle request to capture value and dp_in.
REQ-007 SHALL provide port load_ack  output  1  one-cycle pulse when a captured load becomes visible.
REQ-008 SHALL provide port bcd  output  4  nibble of selected digit, drives the 7-segment converter input.
REQ-009 SHALL provide port an  output  4  digit anodes, active-low, one-hot-low.
REQ-010 SHALL provide port dp  output  1  decimal point of selected digit, active-low.
REQ-011 SHALL provide port frame_tick  output  1  one-cycle pulse at each frame start.

Function
REQ-012 SHALL run prescaler 0..REFRESH_DIV-1 counting every cycle; terminal count (TC) = REFRESH_DIV-1, then wrap to 0.
REQ-013 SHALL advance digit index sel 0->1->2->3->0 on each TC edge only.
REQ-014 SHALL register bcd, an, dp; they update on the same edge sel advances: an = all ones except bit sel low, bcd = active nibble[sel], dp = ~active_dp[sel].
REQ-015 SHALL define frame boundary as the TC edge with sel==3; on it sel->0 and frame_tick is high for the following cycle.
REQ-016 SHALL capture value/dp_in into a pending register on load and set a pending flag; display unchanged until frame boundary (tear-free).
REQ-017 SHALL, at frame boundary with pending set, copy pending to active, clear the flag, and drive load_ack high for exactly the following cycle; the new digit0 is shown on that same edge.
REQ-018 SHALL, when load coincides with the frame-boundary cycle, copy value/dp_in directly to active, discard older pending data, single load_ack.
REQ-019 SHALL, on multiple loads within one frame, keep only the last (last-wins), one load_ack.
REQ-020 SHALL hold load_ack low at frame boundaries with no pending data.

Reset
REQ-021 SHALL on reset: prescaler=0, sel=0, active and pending cleared to 0, pending flag=0, an=4'b1110, bcd=4'h0, dp=1, load_ack=0, frame_tick=0.
REQ-022 SHALL give reset priority over load; reset mid-frame discards pending data, no load_ack.
REQ-023 SHALL start the first frame on the first cycle after reset deasserts.

Configuration
REQ-024 SHALL support macro DISP_SCAN_LZB_EN (leading-zero blanking).
REQ-025 SHALL with DISP_SCAN_LZB_EN defined blank digit i (i=3..1) when its active nibble and all higher nibbles are zero: an stays 4'b1111, dp=1, bcd=4'h0 during its slot; digit0 never blanked; timing unchanged.
REQ-026 SHALL without DISP_SCAN_LZB_EN light all four digits every frame, zeros displayed.

Verification (REFRESH_DIV=4)
REQ-027 SHALL check reset: after reset cycle an=1110, bcd=0, dp=1, load_ack=0, frame_tick=0; frame_tick period 16 cycles.
REQ-028 SHALL check scan: load 16'h1234 dp_in=4'b0010 -> after ack, bcd 4,3,2,1 with an 1110,1101,1011,0111, 4 cycles each, dp=0 only during digit1 slot.
REQ-029 SHALL check tear-free: load 16'h5678 mid-frame -> remaining slots still show 1234 data; load_ack one cycle at boundary; next frame shows 8,7,6,5.
REQ-030 SHALL check last-wins and coincidence: loads 16'h1111 then 16'h2222 same frame -> 2222 shown, one ack; load on boundary cycle -> visible same edge, one ack.
REQ-031 SHALL check LZB: 16'h0070 -> digit3,2 slots an=1111, digit1 bcd=7, digit0 bcd=0; 16'h0000 -> only digit0 lit; without macro all four lit.
REQ-032 SHALL check reset mid-frame with pending load -> reset state, no ack, display 0000.
